// File: rtl/dfi_pkg.sv
// Shared DFI read-return constants and word/burst types.
// Defaults describe 8 phases x 32 bits feeding 256-bit LPDDR4 BL16 bursts.
package dfi_pkg;

  localparam int DFI_NPHASES     = 8;
  localparam int DFI_DW          = 32;
  localparam int DFI_BURST_WORDS = 8;

  typedef logic [DFI_DW-1:0] dfi_word_t;
  typedef dfi_word_t [DFI_BURST_WORDS-1:0] dfi_burst_t;

endpackage

// File: rtl/rd_gather_fifo.sv
// First-word-fall-through burst FIFO; dout reads 0 while empty.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module rd_gather_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dfi_rd_gather.sv
// Compacts valid DFI read phases into full bursts and queues them for the controller.
// The PHY cannot be stalled, so bursts arriving at a full FIFO are dropped and counted.
module dfi_rd_gather
  import dfi_pkg::*;
#(
  parameter int NPHASES     = DFI_NPHASES,
  parameter int DW          = DFI_DW,
  parameter int BURST_WORDS = DFI_BURST_WORDS,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_sys,
  input  logic                          rst_sys_n,
  input  logic                          dfi_init_complete,
  input  logic [NPHASES*DW-1:0]         dfi_rddata,
  input  logic [NPHASES-1:0]            dfi_rddata_valid,
  output logic [BURST_WORDS*DW-1:0]     rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rd_level,
  output logic                          ovf_sticky,
  output logic [15:0]                   drop_count,
  input  logic                          ovf_clear
);

  localparam int IDX_W = $clog2(BURST_WORDS + NPHASES);
  localparam int CNT_W = IDX_W + 1;
  localparam int CAT_N = 2 * BURST_WORDS;

  typedef logic [DW-1:0] word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  word_t                     acc_p0 [BURST_WORDS];
  logic [IDX_W-1:0]          acc_cnt_p0;

  word_t                     cat [CAT_N];
  logic [CNT_W-1:0]          tot;
  word_t                     acc_nxt [BURST_WORDS];
  logic [IDX_W-1:0]          acc_cnt_nxt;
  logic                      vld_p0;
  logic [BURST_WORDS*DW-1:0] burst_p0;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      drop;

  // Held words occupy cat[0..cnt-1]; new valid phases append in ascending order.
  always_comb begin
    for (int k = 0; k < CAT_N; k++) cat[k] = '0;
    for (int i = 0; i < BURST_WORDS; i++) cat[i] = acc_p0[i];
    tot = CNT_W'(acc_cnt_p0);
    for (int p = 0; p < NPHASES; p++) begin
      if (dfi_rddata_valid[p]) begin
        for (int k = 0; k < CAT_N; k++) begin
          if (tot == CNT_W'(k)) cat[k] = dfi_rddata[p*DW +: DW];
        end
        tot = tot + CNT_W'(1);
      end
    end
  end

  always_comb begin
    vld_p0      = dfi_init_complete && (tot >= CNT_W'(BURST_WORDS));
    burst_p0    = '0;
    acc_cnt_nxt = '0;
    for (int i = 0; i < BURST_WORDS; i++) begin
      burst_p0[i*DW +: DW] = cat[i];
      acc_nxt[i]           = cat[i];
    end
    if (vld_p0) begin
      for (int i = 0; i < BURST_WORDS; i++) acc_nxt[i] = cat[i + BURST_WORDS];
      acc_cnt_nxt = IDX_W'(tot - CNT_W'(BURST_WORDS));
    end else if (dfi_init_complete) begin
      acc_cnt_nxt = IDX_W'(tot);
    end
  end

  // ---- stage p0: accumulator register ----
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) acc_cnt_p0 <= '0;
    else            acc_cnt_p0 <= acc_cnt_nxt;
  end

  always_ff @(posedge clk_sys) begin
    acc_p0 <= acc_nxt;
  end

  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;
  assign drop     = vld_p0 && fifo_full && !pop;

  rd_gather_fifo #(
    .WIDTH (BURST_WORDS * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .push  (vld_p0),
    .din   (burst_p0),
    .pop   (pop),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (rd_level)
  );

  // A clear coinciding with a drop leaves exactly that one drop recorded.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end else if (ovf_clear) begin
      ovf_sticky <= drop;
      drop_count <= {15'd0, drop};
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      drop_count <= sat_inc16(drop_count);
    end
  end

endmodule

// File: tb/tb_dfi_rd_gather.sv
// Directed bench for dfi_rd_gather with hand-computed expected bursts.
module tb_dfi_rd_gather;

  logic         clk_sys = 1'b0;
  logic         rst_sys_n;
  logic         dfi_init_complete;
  logic [255:0] dfi_rddata;
  logic [7:0]   dfi_rddata_valid;
  logic [255:0] rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [2:0]   rd_level;
  logic         ovf_sticky;
  logic [15:0]  drop_count;
  logic         ovf_clear;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk_sys = ~clk_sys;

  dfi_rd_gather dut (
    .clk_sys           (clk_sys),
    .rst_sys_n         (rst_sys_n),
    .dfi_init_complete (dfi_init_complete),
    .dfi_rddata        (dfi_rddata),
    .dfi_rddata_valid  (dfi_rddata_valid),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_level          (rd_level),
    .ovf_sticky        (ovf_sticky),
    .drop_count        (drop_count),
    .ovf_clear         (ovf_clear)
  );

  function automatic logic [255:0] b8(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2, input logic [31:0] w3,
                                      input logic [31:0] w4, input logic [31:0] w5,
                                      input logic [31:0] w6, input logic [31:0] w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  function automatic logic [255:0] seqb(input logic [31:0] base);
    logic [255:0] r;
    for (int p = 0; p < 8; p++) r[p*32 +: 32] = base + 32'(p);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ini, input logic [7:0] m, input logic [255:0] d);
    dfi_init_complete = ini;
    dfi_rddata_valid  = m;
    dfi_rddata        = d;
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    rst_sys_n         = 1'b0;
    dfi_init_complete = 1'b0;
    dfi_rddata        = '0;
    dfi_rddata_valid  = '0;
    rd_ready          = 1'b0;
    ovf_clear         = 1'b0;
    #12;
    chk("rst_valid",  256'(rd_valid),   256'(0));
    chk("rst_level",  256'(rd_level),   256'(0));
    chk("rst_data",   rd_data,          256'(0));
    chk("rst_sticky", 256'(ovf_sticky), 256'(0));
    chk("rst_drops",  256'(drop_count), 256'(0));
    rst_sys_n = 1'b1;
    cyc(1'b1, 8'h00, '0);

    // Full cycle
    rd_ready = 1'b1;
    cyc(1'b1, 8'hFF, seqb(32'h0));
    chk("full_valid", 256'(rd_valid), 256'(1));
    chk("full_data",  rd_data,        seqb(32'h0));
    chk("full_level", 256'(rd_level), 256'(1));
    cyc(1'b1, 8'h00, '0);
    chk("full_pop_level", 256'(rd_level), 256'(0));
    chk("full_pop_valid", 256'(rd_valid), 256'(0));
    chk("full_pop_data",  rd_data,        256'(0));

    // Split burst
    rd_ready = 1'b0;
    cyc(1'b1, 8'hF0, b8(32'hEE, 32'hEE, 32'hEE, 32'hEE, 32'hA4, 32'hA5, 32'hA6, 32'hA7));
    chk("split_a_level", 256'(rd_level), 256'(0));
    cyc(1'b1, 8'h0F, b8(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hEE, 32'hEE, 32'hEE, 32'hEE));
    chk("split_b_level", 256'(rd_level), 256'(1));
    chk("split_data", rd_data,
        b8(32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hB0, 32'hB1, 32'hB2, 32'hB3));
    rd_ready = 1'b1;
    cyc(1'b1, 8'h00, '0);
    rd_ready = 1'b0;
    chk("split_drain", 256'(rd_level), 256'(0));

    // Sparse mask
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b1, 8'hAA, b8(32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7));
      chk("sparse_level", 256'(rd_level), 256'(c / 2));
    end
    chk("sparse_head", rd_data,
        b8(32'hC1, 32'hC3, 32'hC5, 32'hC7, 32'hC1, 32'hC3, 32'hC5, 32'hC7));
    rd_ready = 1'b1;
    cyc(1'b1, 8'h00, '0);
    chk("sparse_second", rd_data,
        b8(32'hC1, 32'hC3, 32'hC5, 32'hC7, 32'hC1, 32'hC3, 32'hC5, 32'hC7));
    cyc(1'b1, 8'h00, '0);
    chk("sparse_empty", 256'(rd_level), 256'(0));
    cyc(1'b1, 8'hFF, seqb(32'hE0));
    chk("sparse_acc_clean", rd_data, seqb(32'hE0));
    cyc(1'b1, 8'h00, '0);
    rd_ready = 1'b0;

    // Overflow
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 8'hFF, seqb(32'(256 * k)));
      if (k == 4) chk("ovf_before", 256'(ovf_sticky), 256'(0));
    end
    chk("ovf_level",  256'(rd_level),   256'(4));
    chk("ovf_sticky", 256'(ovf_sticky), 256'(1));
    chk("ovf_drops",  256'(drop_count), 256'(1));
    chk("ovf_head",   rd_data,          seqb(32'h100));
    ovf_clear = 1'b1;
    cyc(1'b1, 8'h00, '0);
    ovf_clear = 1'b0;
    chk("clr_sticky", 256'(ovf_sticky), 256'(0));
    chk("clr_drops",  256'(drop_count), 256'(0));
    chk("clr_level",  256'(rd_level),   256'(4));
    rd_ready = 1'b1;
    cyc(1'b1, 8'hFF, seqb(32'h600));
    rd_ready = 1'b0;
    chk("fullpop_level",  256'(rd_level),   256'(4));
    chk("fullpop_sticky", 256'(ovf_sticky), 256'(0));
    chk("fullpop_head",   rd_data,          seqb(32'h200));
    cyc(1'b1, 8'hFF, seqb(32'h700));
    chk("drop2_count", 256'(drop_count), 256'(1));
    ovf_clear = 1'b1;
    cyc(1'b1, 8'hFF, seqb(32'h800));
    ovf_clear = 1'b0;
    chk("clrdrop_sticky", 256'(ovf_sticky), 256'(1));
    chk("clrdrop_count",  256'(drop_count), 256'(1));
    chk("clrdrop_head",   rd_data,          seqb(32'h200));
    rd_ready = 1'b1;
    repeat (4) cyc(1'b1, 8'h00, '0);
    rd_ready = 1'b0;
    chk("ovf_drained", 256'(rd_level), 256'(0));

    // Init drop
    cyc(1'b1, 8'h07, b8(32'hF0, 32'hF1, 32'hF2, 32'hEE, 32'hEE, 32'hEE, 32'hEE, 32'hEE));
    cyc(1'b0, 8'hFF, seqb(32'hBAD0));
    cyc(1'b0, 8'hFF, seqb(32'hBAD0));
    chk("init_low_level", 256'(rd_level), 256'(0));
    cyc(1'b1, 8'hFF, seqb(32'hD0));
    chk("init_level", 256'(rd_level), 256'(1));
    chk("init_data",  rd_data,        seqb(32'hD0));
    cyc(1'b0, 8'hFF, seqb(32'hBAD0));
    chk("init_retain_level", 256'(rd_level), 256'(1));
    chk("init_retain_data",  rd_data,        seqb(32'hD0));
    cyc(1'b1, 8'h00, '0);
    chk("init_no_extra", 256'(rd_level), 256'(1));
    rd_ready = 1'b1;
    cyc(1'b1, 8'h00, '0);
    rd_ready = 1'b0;

    // Async reset mid-cycle
    cyc(1'b1, 8'hFF, seqb(32'h5000));
    cyc(1'b1, 8'hFF, seqb(32'h5100));
    cyc(1'b1, 8'h1F, seqb(32'h5200));
    chk("prerst_level", 256'(rd_level), 256'(2));
    dfi_rddata_valid = 8'h00;
    #2;
    rst_sys_n = 1'b0;
    #1;
    chk("arst_valid",  256'(rd_valid),   256'(0));
    chk("arst_level",  256'(rd_level),   256'(0));
    chk("arst_data",   rd_data,          256'(0));
    chk("arst_sticky", 256'(ovf_sticky), 256'(0));
    chk("arst_drops",  256'(drop_count), 256'(0));
    #2;
    rst_sys_n = 1'b1;
    cyc(1'b1, 8'hFF, seqb(32'h4700));
    chk("post_rst_level", 256'(rd_level), 256'(1));
    chk("post_rst_data",  rd_data,        seqb(32'h4700));
    cyc(1'b1, 8'h00, '0);
    chk("post_rst_single", 256'(rd_level), 256'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
